// File: rtl/sig_pkg.sv
// Shared constants, state encoding and header record for the signature stream parser.
package sig_pkg;
  localparam int SIG_W     = 19584;
  localparam int WORD_W    = 32;
  localparam int NWORDS    = SIG_W / WORD_W;
  localparam int HDR_WORDS = 16;
  localparam int H_W       = 256;
  localparam int SALT_W    = 256;
  localparam int CNT_W     = 10;

  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(HDR_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(NWORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_BODY = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  typedef struct packed {
    logic [H_W-1:0]    h;
    logic [SALT_W-1:0] salt;
  } hdr_t;
endpackage

// File: rtl/sig_word_shifter.sv
// Purpose: SIG_W-bit shift register, one WORD_W word shifted in at the bottom per load.
// Latency: new word visible the cycle after load_en.
// Backpressure: none; shifts only when the owner asserts load_en.
module sig_word_shifter
  import sig_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [WORD_W-1:0] word_in,
  output logic [SIG_W-1:0]  sigma_buf
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sigma_buf <= '0;
    end else if (load_en) begin
      sigma_buf <= {sigma_buf[SIG_W-WORD_W-1:0], word_in};
    end
  end

endmodule

// File: rtl/sig_stream_parser.sv
// Purpose: rebuilds a signature from a 32-bit word stream; length check under SIG_STREAM_PARSER_LEN_CHECK_EN.
// Latency: header valid on the 16th transfer edge; parse_stop one cycle after the final transfer.
// Backpressure: word_ready high only in HDR/BODY; source holds word_in while word_ready is low.
module sig_stream_parser
  import sig_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              parse_start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic              header_valid,
  output logic [H_W-1:0]    H_out,
  output logic [SALT_W-1:0] salt_out,
  output logic [SIG_W-1:0]  sigma_buf,
  output logic              parse_stop,
  output logic              parse_err
);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                xfer;
  logic                len_bad;
  logic                hdr_vld_q;
  hdr_t                hdr_q;
  logic [H_W+SALT_W-1:0] hdr_win;

  assign word_ready   = (state == ST_HDR) || (state == ST_BODY);
  assign xfer         = word_valid && word_ready;
  assign parse_stop   = (state == ST_DONE) || (state == ST_ERR);
  assign header_valid = hdr_vld_q;
  assign H_out        = hdr_q.h;
  assign salt_out     = hdr_q.salt;

  // Low 512 bits of the buffer as they will look after this cycle's shift.
  assign hdr_win = {sigma_buf[H_W+SALT_W-WORD_W-1:0], word_in};

`ifdef SIG_STREAM_PARSER_LEN_CHECK_EN
  assign len_bad   = word_last ? (cnt != CNT_LAST) : (cnt == CNT_LAST);
  assign parse_err = (state == ST_ERR);
`else
  logic unused_word_last;
  assign unused_word_last = word_last;
  assign len_bad   = 1'b0;
  assign parse_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (parse_start) state_nxt = ST_HDR;
      end
      ST_HDR: begin
        if (!parse_start)                     state_nxt = ST_IDLE;
        else if (xfer && len_bad)             state_nxt = ST_ERR;
        else if (xfer && cnt == CNT_HDR_LAST) state_nxt = ST_BODY;
      end
      ST_BODY: begin
        if (!parse_start)                 state_nxt = ST_IDLE;
        else if (xfer && len_bad)         state_nxt = ST_ERR;
        else if (xfer && cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE, ST_ERR: begin
        if (!parse_start) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hdr_vld_q <= 1'b0;
      hdr_q     <= '0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && state_nxt == ST_HDR) begin
        cnt <= '0;
      end else if (xfer) begin
        cnt <= cnt + CNT_W'(1);
      end

      // DONE keeps header_valid; a new session, an abort or an error drops it.
      if (state_nxt == ST_HDR && state == ST_IDLE) begin
        hdr_vld_q <= 1'b0;
      end else if (state_nxt == ST_ERR) begin
        hdr_vld_q <= 1'b0;
      end else if (state_nxt == ST_IDLE && (state == ST_HDR || state == ST_BODY)) begin
        hdr_vld_q <= 1'b0;
      end else if (state == ST_HDR && state_nxt == ST_BODY) begin
        hdr_vld_q <= 1'b1;
        hdr_q     <= hdr_win;
      end
    end
  end

  sig_word_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load_en   (xfer),
    .word_in   (word_in),
    .sigma_buf (sigma_buf)
  );

endmodule

// File: tb/tb_sig_stream_parser.sv
// Directed bench for sig_stream_parser: nominal, stalls, release, abort, async reset, length check.
`timescale 1ns/1ps
module tb_sig_stream_parser;
  import sig_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              parse_start = 1'b0;
  logic [WORD_W-1:0] word_in = '0;
  logic              word_valid = 1'b0;
  logic              word_last = 1'b0;
  logic              word_ready;
  logic              header_valid;
  logic [H_W-1:0]    H_out;
  logic [SALT_W-1:0] salt_out;
  logic [SIG_W-1:0]  sigma_buf;
  logic              parse_stop;
  logic              parse_err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  sig_stream_parser dut (
    .clk          (clk),
    .reset        (reset),
    .parse_start  (parse_start),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_last    (word_last),
    .word_ready   (word_ready),
    .header_valid (header_valid),
    .H_out        (H_out),
    .salt_out     (salt_out),
    .sigma_buf    (sigma_buf),
    .parse_stop   (parse_stop),
    .parse_err    (parse_err)
  );

  // Signature where word k (k=0 first on the wire) equals base+k, word 0 at the top.
  function automatic logic [SIG_W-1:0] exp_sig(input logic [31:0] base);
    logic [SIG_W-1:0] v;
    v = '0;
    for (int k = 0; k < NWORDS; k++) v[SIG_W-1-WORD_W*k -: WORD_W] = base + 32'(k);
    return v;
  endfunction

  function automatic logic [255:0] exp_8words(input logic [31:0] base);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[255-32*i -: 32] = base + 32'(i);
    return v;
  endfunction

  function automatic int diff_words(input logic [SIG_W-1:0] a, input logic [SIG_W-1:0] b);
    int n;
    n = 0;
    for (int k = 0; k < NWORDS; k++)
      if (a[WORD_W*k +: WORD_W] !== b[WORD_W*k +: WORD_W]) n++;
    return n;
  endfunction

  // All tasks begin and end 1ns after a rising edge.
  task automatic start_session();
    parse_start = 1'b1;
    checks++;
    if (word_ready !== 1'b0) $display("FAIL start_rdy_idle: got %b want 0", word_ready);
    else passes++;
    @(posedge clk); #1;
    checks++;
    if (word_ready !== 1'b1) $display("FAIL start_rdy_hdr: got %b want 1", word_ready);
    else passes++;
    checks++;
    if (header_valid !== 1'b0) $display("FAIL start_hdr_clr: got %b want 0", header_valid);
    else passes++;
  endtask

  task automatic feed(input logic [31:0] base, input int n, input bit stall,
                      input int last_idx, input bit chk_hdr);
    int  k;
    int  cyc;
    bit  v;
    bit  x;
    k = 0;
    cyc = 0;
    while (k < n && cyc < 4000) begin
      v = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      word_valid = v;
      word_in    = base + 32'(k);
      word_last  = (k == last_idx);
      x = v && (word_ready === 1'b1);
      @(posedge clk); #1;
      cyc++;
      if (x) begin
        k++;
        if (chk_hdr) begin
          checks++;
          if (header_valid !== (k >= HDR_WORDS))
            $display("FAIL feed_hdr_valid@%0d: got %b want %b", k, header_valid, (k >= HDR_WORDS));
          else passes++;
        end
      end
      if (k < n) begin
        checks++;
        if (parse_stop !== 1'b0) $display("FAIL feed_stop_early@%0d: got %b want 0", k, parse_stop);
        else passes++;
      end
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
    checks++;
    if (k != n) $display("FAIL feed_timeout: got %0d words want %0d", k, n);
    else passes++;
  endtask

  task automatic check_complete(input logic [31:0] base);
    logic [SIG_W-1:0] e;
    int d;
    e = exp_sig(base);
    d = diff_words(sigma_buf, e);
    checks++;
    if (parse_stop !== 1'b1) $display("FAIL done_stop: got %b want 1", parse_stop); else passes++;
    checks++;
    if (word_ready !== 1'b0) $display("FAIL done_rdy: got %b want 0", word_ready); else passes++;
    checks++;
    if (parse_err !== 1'b0) $display("FAIL done_err: got %b want 0", parse_err); else passes++;
    checks++;
    if (header_valid !== 1'b1) $display("FAIL done_hdr_valid: got %b want 1", header_valid); else passes++;
    checks++;
    if (H_out !== exp_8words(base)) $display("FAIL done_H: got %h want %h", H_out, exp_8words(base));
    else passes++;
    checks++;
    if (salt_out !== exp_8words(base + 32'd8))
      $display("FAIL done_salt: got %h want %h", salt_out, exp_8words(base + 32'd8));
    else passes++;
    checks++;
    if (sigma_buf[31:0] !== base + 32'd611)
      $display("FAIL done_last_word: got %h want %h", sigma_buf[31:0], base + 32'd611);
    else passes++;
    checks++;
    if (d !== 0) $display("FAIL done_sigma: got %0d bad words want 0", d); else passes++;
  endtask

  task automatic end_session();
    parse_start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (parse_stop !== 1'b0) $display("FAIL end_stop: got %b want 0", parse_stop); else passes++;
    checks++;
    if (parse_err !== 1'b0) $display("FAIL end_err: got %b want 0", parse_err); else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({word_ready, header_valid, parse_stop, parse_err} !== 4'b0)
      $display("FAIL reset_ctl: got %b want 0000", {word_ready, header_valid, parse_stop, parse_err});
    else passes++;
    checks++;
    if ({H_out, salt_out} !== '0) $display("FAIL reset_hdr: got %h want 0", H_out); else passes++;
    checks++;
    if (diff_words(sigma_buf, '0) !== 0) $display("FAIL reset_sigma: got nonzero want 0"); else passes++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    start_session();
    feed(32'h0, NWORDS, 1'b0, NWORDS - 1, 1'b1);
    check_complete(32'h0);
  endtask

  task automatic test_release();
    logic [31:0] lo;
    lo = sigma_buf[31:0];
    for (int i = 0; i < 20; i++) begin
      word_valid = 1'b1;
      word_in    = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      checks++;
      if (parse_stop !== 1'b1 || word_ready !== 1'b0)
        $display("FAIL hold_done@%0d: got stop=%b rdy=%b want stop=1 rdy=0", i, parse_stop, word_ready);
      else passes++;
    end
    word_valid = 1'b0;
    checks++;
    if (sigma_buf[31:0] !== lo) $display("FAIL hold_consumed: got %h want %h", sigma_buf[31:0], lo);
    else passes++;
    parse_start = 1'b0;
    #1;
    checks++;
    if (parse_stop !== 1'b1) $display("FAIL release_same_cycle: got %b want 1", parse_stop); else passes++;
    @(posedge clk); #1;
    checks++;
    if (parse_stop !== 1'b0) $display("FAIL release_stop: got %b want 0", parse_stop); else passes++;
    checks++;
    if (header_valid !== 1'b1) $display("FAIL release_hdr_kept: got %b want 1", header_valid); else passes++;
  endtask

  task automatic test_stalls();
    start_session();
    feed(32'h0, NWORDS, 1'b1, NWORDS - 1, 1'b1);
    check_complete(32'h0);
    end_session();
  endtask

  task automatic test_abort();
    start_session();
    feed(32'h1000_0000, 100, 1'b0, -1, 1'b1);
    parse_start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({header_valid, parse_stop, word_ready} !== 3'b000)
      $display("FAIL abort_state: got hv/stop/rdy=%b want 000", {header_valid, parse_stop, word_ready});
    else passes++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (parse_stop !== 1'b0) $display("FAIL abort_no_stop@%0d: got %b want 0", i, parse_stop); else passes++;
    end
    start_session();
    feed(32'hA5A5_0000, NWORDS, 1'b0, NWORDS - 1, 1'b1);
    check_complete(32'hA5A5_0000);
    end_session();
  endtask

  task automatic test_reset_mid();
    start_session();
    feed(32'h2000_0000, 300, 1'b0, -1, 1'b0);
    word_valid = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if ({word_ready, header_valid, parse_stop, parse_err} !== 4'b0)
      $display("FAIL rst_mid_ctl: got %b want 0000", {word_ready, header_valid, parse_stop, parse_err});
    else passes++;
    checks++;
    if (H_out !== '0 || salt_out !== '0) $display("FAIL rst_mid_hdr: got %h want 0", H_out); else passes++;
    checks++;
    if (diff_words(sigma_buf, '0) !== 0) $display("FAIL rst_mid_sigma: got nonzero want 0"); else passes++;
    parse_start = 1'b0;
    word_valid  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (word_ready !== 1'b0) $display("FAIL rst_mid_idle: got %b want 0", word_ready); else passes++;
  endtask

`ifdef SIG_STREAM_PARSER_LEN_CHECK_EN
  task automatic test_len_check();
    start_session();
    feed(32'h3000_0000, 401, 1'b0, 400, 1'b0);
    checks++;
    if ({parse_err, parse_stop, word_ready, header_valid} !== 4'b1100)
      $display("FAIL len_early: got err/stop/rdy/hv=%b want 1100",
               {parse_err, parse_stop, word_ready, header_valid});
    else passes++;
    end_session();
    start_session();
    feed(32'h3000_0000, NWORDS, 1'b0, -1, 1'b0);
    checks++;
    if ({parse_err, parse_stop, word_ready} !== 3'b110)
      $display("FAIL len_missing: got err/stop/rdy=%b want 110", {parse_err, parse_stop, word_ready});
    else passes++;
    end_session();
  endtask
`else
  task automatic test_len_check();
    start_session();
    feed(32'h3000_0000, NWORDS, 1'b0, 400, 1'b1);
    check_complete(32'h3000_0000);
    end_session();
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_release();
    test_stalls();
    test_abort();
    test_reset_mid();
    test_len_check();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sig_stream_parser.md
Name: sig_stream_parser

Overview:
- Receiving end of the signer's `sigma_out`. It accepts a Picnic-on-SM4 signature as a stream of 32-bit words over a valid/ready handshake.
- It rebuilds the full 19584-bit signature vector and exposes the challenge hash H and the salt as soon as the header has arrived.
- It sits at the front of the verifier datapath and uses the same start/stop session handshake as the signing top level.

Parameters:
- WORD_W, 32, stream word width in bits.
- SIG_W, 19584, signature width in bits; must be a multiple of WORD_W.
- NWORDS, SIG_W/WORD_W = 612, words per signature (derived localparam).
- HDR_WORDS, 16, header words: 8 words of H, then 8 words of salt.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- parse_start  in  1  session request; level held high until parse_stop has been seen.
- word_in  in  WORD_W  stream data.
- word_valid  in  1  word_in is valid.
- word_last  in  1  marks the final word of the signature.
- word_ready  out  1  parser accepts a word this cycle.
- header_valid  out  1  H_out and salt_out are valid.
- H_out  out  256  challenge hash, signature bits [19583:19328].
- salt_out  out  256  salt, signature bits [19327:19072].
- sigma_buf  out  SIG_W  reassembled signature; word 0 occupies [SIG_W-1:SIG_W-32].
- parse_stop  out  1  session finished (success or error).
- parse_err  out  1  length error; qualified by parse_stop.

Behaviour:
- Reset (reset=0, asynchronous): every output and internal register is cleared to 0, including sigma_buf, H_out, salt_out and the word counter. Reset mid-session discards partial data; no stop pulse is produced.
- States are IDLE, HDR, BODY, DONE and ERR.
- A transfer happens on a cycle where word_valid && word_ready. On each transfer: sigma_buf <= {sigma_buf[SIG_W-33:0], word_in} and cnt <= cnt+1. cnt is 10 bits and never wraps because the FSM leaves BODY at cnt==NWORDS-1.
- IDLE:
  - word_ready=0.
  - If parse_start=1 and parse_stop=0: clear cnt and header_valid, go to HDR. sigma_buf keeps its old value until overwritten.
  - word_ready rises the cycle after the IDLE→HDR transition, so the first transfer is at the earliest 2 cycles after parse_start rises.
- HDR:
  - word_ready=1.
  - On the transfer with cnt==15: latch H_out = shifted value bits [511:256] and salt_out = bits [255:0]; set header_valid=1 in the same edge; go to BODY.
- BODY:
  - word_ready=1.
  - On the transfer with cnt==NWORDS-1: go to DONE, word_ready=0, parse_stop=1 on the following cycle.
  - Completion latency is one cycle after the final transfer.
- DONE:
  - Hold parse_stop=1 and all data outputs stable.
  - When parse_start falls: parse_stop <= 0, go to IDLE. header_valid stays high until the next session starts.
- parse_start falling in HDR or BODY aborts the session: go to IDLE, header_valid=0, parse_stop stays 0, and the partial sigma_buf is not valid.
- parse_start rising while a session is active is ignored (it is level-based).
- A word presented while word_ready=0 is not consumed; the source must hold it.
- word_valid low stalls the parser indefinitely with no timeout.

Optional Feature:
- Macro SIG_STREAM_PARSER_LEN_CHECK_EN.
- Defined:
  - word_last asserted on a transfer with cnt<NWORDS-1 → ERR.
  - A transfer with cnt==NWORDS-1 and word_last=0 → ERR.
  - ERR: word_ready=0, parse_err=1 and parse_stop=1 on the next cycle, header_valid forced 0. Release on parse_start falling, exactly as DONE; parse_err clears with parse_stop.
- Not defined: word_last is ignored, parse_err is tied 0, and the ERR state is absent.

Decomposition:
- Shared package sig_pkg holds:
  - localparams SIG_W=19584, WORD_W=32, NWORDS=612, HDR_WORDS=16, H_W=256, SALT_W=256;
  - state encoding constants ST_IDLE..ST_ERR, 3 bits.
- Natural sub-module: sig_word_shifter, the SIG_W shift register with load enable. The FSM and counter stay in the top module.

Test Plan:
- Nominal: start, 612 words with word k = 32'h0000_0000+k and word_last on k=611, valid held high → H_out={k=0..7}, salt_out={k=8..15}, sigma_buf[31:0]=32'd611, parse_stop 1 cycle after the last transfer, parse_err=0.
- Stalls: word_valid random 50% with the same data → identical sigma_buf; no words dropped or duplicated; header_valid rises exactly on the 16th transfer.
- Handshake release: hold parse_start=1 for 20 cycles after done → parse_stop stays 1 and word_ready stays 0; drop parse_start → parse_stop=0 the next cycle; re-raise → new session, cnt restarts at 0.
- Abort: drop parse_start after 100 words → IDLE, header_valid=0, parse_stop never asserts; a following full session parses correctly.
- Reset mid-BODY at word 300 → all outputs 0 immediately (asynchronous), word_ready=0.
- LEN_CHECK_EN: word_last on word 400 → parse_err=1 and parse_stop=1 next cycle, word_ready=0. Also: 612 words without word_last → parse_err=1.
